alu_issue: RTL and testbench
============================

# alu_issue

Sequencer that owns the 8-entry general register file and drives the combinational ALU. It accepts one register-to-register instruction at a time over a valid/ready handshake and presents registered operands and opcode to the ALU. It captures the ALU result and writes it back to the destination register. It sits between instruction fetch/decode and the ALU, and also provides a register load port and a debug read port.

## Interface
- NUM_REGS, 8, register file depth; address width is log2(NUM_REGS) = 3.
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- instr_valid  in  1  instruction offered.
- instr_ready  out  1  block can accept an instruction this cycle.
- instr_op  in  `ALU_OP_WIDTH  ALU opcode (`ALU_OP_ADD/LSL/AND/NOT`).
- instr_rd / instr_rs / instr_rt  in  3 each  destination, source, and second-source register indices.
- ld_valid  in  1  direct register write request.
- ld_addr  in  3  register index for the direct write.
- ld_data  in  `REG_WIDTH  data for the direct write.
- dbg_addr  in  3  debug read index.
- dbg_data  out  `REG_WIDTH  registered debug read data.
- alu_op  out  `ALU_OP_WIDTH  opcode to the ALU.
- alu_rs_val / alu_rt_val  out  `REG_WIDTH each  operands to the ALU.
- alu_result  in  `REG_WIDTH  combinational ALU result.
- done  out  1  one-cycle pulse when the writeback occurs.
- done_rd  out  3  register index written.
- done_val  out  `REG_WIDTH  value written.

## Operation
- FSM states and transitions:
  - IDLE → ISSUE when instr_valid && instr_ready.
  - ISSUE → WRITE unconditionally.
  - WRITE → IDLE unconditionally.
- instr_ready = (state == IDLE) && !ld_valid. A load always wins over an instruction in the same cycle.
- Accept edge (IDLE): latch op and rd. Latch alu_rs_val = rf[rs] and alu_rt_val = rf[rt], read at that edge.
- ISSUE: alu_op and alu_* are stable for the whole cycle. At the end of the cycle, capture alu_result into a result register.
- WRITE: at the end of the cycle, write the result register to rf[rd]. done is high for exactly this cycle, with done_rd = rd and done_val = the captured result.
- Load port: ld_valid is honoured only in IDLE, and rf[ld_addr] <= ld_data at the edge. In ISSUE and WRITE, ld_valid is ignored and dropped; the producer must hold the request until IDLE.
- Operands read during IDLE see all prior writebacks, because WRITE completes before IDLE. No forwarding is needed.
- rd == rs or rd == rt is legal: operands were latched at accept, so the old value is used.
- dbg_data <= rf[dbg_addr] every cycle in every state. The read is one cycle late and reflects the array contents before that edge's write.
- Opcode outside the defined set is passed through unchanged; whatever the ALU returns is written back.

## Timing
- Reset values: state IDLE, all rf entries 0, alu_op 0, alu_rs_val 0, alu_rt_val 0, done 0, done_rd 0, done_val 0, dbg_data 0. instr_ready is 1 after reset whenever ld_valid is 0.
- Accept edge = cycle 0. ALU driven in cycle 1. Writeback edge and done high in cycle 2. IDLE again in cycle 3.
- Throughput is one instruction per 3 cycles. The next accept is possible at the end of cycle 3.
- Reset asserted mid-operation aborts immediately: no writeback, no done pulse, and the rf is cleared.

## Configuration
- ALU_ISSUE_R0_ZERO_EN:
  - Defined: register 0 is hardwired to zero. Writes to index 0 (writeback or load) are discarded, and reads of index 0 (operands, dbg) return 0. done still pulses with done_rd = 0 and done_val = the computed result.
  - Undefined: register 0 is an ordinary register.

## Test plan
Values assume REG_WIDTH=16.
- Reset then dbg sweep: every dbg_addr returns 0x0000; instr_ready = 1; done = 0.
- Load r1=0x0003, r2=0x0005, then ADD rd=3 rs=1 rt=2 → alu_rs_val=0x0003 and alu_rt_val=0x0005 in cycle 1; done in cycle 2 with done_rd=3 and done_val=0x0008; dbg r3 = 0x0008.
- LSL r4 = r1 << r1 with r1=0x0003 → done_val=0x0018. Then NOT r4 = ~r4 (rd==rs) → done_val=0xFFE7.
- ld_valid and instr_valid asserted together in IDLE → load performed, instr_ready=0 that cycle, instruction accepted on the next cycle. A ld_valid pulse during ISSUE leaves its target unchanged.
- Back-to-back instr_valid held high → accepts are exactly 3 cycles apart; done pulses are single-cycle and 3 cycles apart.
- reset_n pulsed low during ISSUE of an ADD → no done pulse; all registers read 0. With ALU_ISSUE_R0_ZERO_EN defined, loading r0=0x1234 leaves dbg r0 = 0x0000.

Source files
------------

// File: rtl/alu_issue.sv
// alu_issue: owns the 8-entry register file and sequences one ALU instruction every 3 cycles.
// Optional feature macro ALU_ISSUE_R0_ZERO_EN: register 0 reads as zero and ignores writes.
`ifndef REG_WIDTH
`define REG_WIDTH 16
`endif
`ifndef ALU_OP_WIDTH
`define ALU_OP_WIDTH 2
`endif
`ifndef ALU_OP_ADD
`define ALU_OP_ADD 2'd0
`endif
`ifndef ALU_OP_LSL
`define ALU_OP_LSL 2'd1
`endif
`ifndef ALU_OP_AND
`define ALU_OP_AND 2'd2
`endif
`ifndef ALU_OP_NOT
`define ALU_OP_NOT 2'd3
`endif

// state | meaning
// IDLE  | accepting loads or one instruction; load has priority
// ISSUE | operands/opcode presented to ALU; result captured at end of cycle
// WRITE | result written to rf[rd]; done pulses
module alu_issue #(
    parameter int NUM_REGS = 8,
    localparam int AW = $clog2(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     instr_valid,
    output logic                     instr_ready,
    input  logic [`ALU_OP_WIDTH-1:0] instr_op,
    input  logic [AW-1:0]            instr_rd,
    input  logic [AW-1:0]            instr_rs,
    input  logic [AW-1:0]            instr_rt,
    input  logic                     ld_valid,
    input  logic [AW-1:0]            ld_addr,
    input  logic [`REG_WIDTH-1:0]    ld_data,
    input  logic [AW-1:0]            dbg_addr,
    output logic [`REG_WIDTH-1:0]    dbg_data,
    output logic [`ALU_OP_WIDTH-1:0] alu_op,
    output logic [`REG_WIDTH-1:0]    alu_rs_val,
    output logic [`REG_WIDTH-1:0]    alu_rt_val,
    input  logic [`REG_WIDTH-1:0]    alu_result,
    output logic                     done,
    output logic [AW-1:0]            done_rd,
    output logic [`REG_WIDTH-1:0]    done_val
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t                  state, state_nxt;
    logic [`REG_WIDTH-1:0]   rf [NUM_REGS];
    logic [AW-1:0]           rd_q;
    logic                    accept;
    logic                    wr_en;
    logic [AW-1:0]           wr_addr;
    logic [`REG_WIDTH-1:0]   wr_data;

    always_comb begin
        state_nxt   = state;
        instr_ready = 1'b0;
        case (state)
            IDLE: begin
                instr_ready = !ld_valid;
                if (instr_valid && !ld_valid) state_nxt = ISSUE;
            end
            ISSUE:   state_nxt = WRITE;
            WRITE:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign accept = instr_valid && instr_ready;

    // Loads only land in IDLE and writebacks only in WRITE, so one write port suffices.
    always_comb begin
        wr_en   = ((state == IDLE) && ld_valid) || (state == WRITE);
        wr_addr = (state == IDLE) ? ld_addr : done_rd;
        wr_data = (state == IDLE) ? ld_data : done_val;
`ifdef ALU_ISSUE_R0_ZERO_EN
        if (wr_addr == '0) wr_en = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            alu_op     <= '0;
            alu_rs_val <= '0;
            alu_rt_val <= '0;
            rd_q       <= '0;
            done       <= 1'b0;
            done_rd    <= '0;
            done_val   <= '0;
            dbg_data   <= '0;
            for (int i = 0; i < NUM_REGS; i++) rf[i] <= '0;
        end else begin
            state    <= state_nxt;
            dbg_data <= rf[dbg_addr];
            done     <= (state == ISSUE);
            if (accept) begin
                alu_op     <= instr_op;
                rd_q       <= instr_rd;
                alu_rs_val <= rf[instr_rs];
                alu_rt_val <= rf[instr_rt];
            end
            // done_val doubles as the captured-result register for the WRITE cycle.
            if (state == ISSUE) begin
                done_rd  <= rd_q;
                done_val <= alu_result;
            end
            if (wr_en) rf[wr_addr] <= wr_data;
        end
    end

endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: directed scoreboard bench for alu_issue with a behavioural ALU attached.
`ifndef REG_WIDTH
`define REG_WIDTH 16
`endif
`ifndef ALU_OP_WIDTH
`define ALU_OP_WIDTH 2
`endif
`ifndef ALU_OP_ADD
`define ALU_OP_ADD 2'd0
`endif
`ifndef ALU_OP_LSL
`define ALU_OP_LSL 2'd1
`endif
`ifndef ALU_OP_AND
`define ALU_OP_AND 2'd2
`endif
`ifndef ALU_OP_NOT
`define ALU_OP_NOT 2'd3
`endif

module tb_alu_issue;
`ifdef ALU_ISSUE_R0_ZERO_EN
    localparam bit R0EN = 1'b1;
`else
    localparam bit R0EN = 1'b0;
`endif
    localparam int W  = `REG_WIDTH;
    localparam int OW = `ALU_OP_WIDTH;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          instr_valid = 1'b0;
    logic          instr_ready;
    logic [OW-1:0] instr_op = '0;
    logic [2:0]    instr_rd = '0, instr_rs = '0, instr_rt = '0;
    logic          ld_valid = 1'b0;
    logic [2:0]    ld_addr = '0;
    logic [W-1:0]  ld_data = '0;
    logic [2:0]    dbg_addr = '0;
    logic [W-1:0]  dbg_data;
    logic [OW-1:0] alu_op;
    logic [W-1:0]  alu_rs_val, alu_rt_val, alu_result;
    logic          done;
    logic [2:0]    done_rd;
    logic [W-1:0]  done_val;

    always #5 clk = ~clk;

    alu_issue #(.NUM_REGS(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_op(instr_op),
        .instr_rd(instr_rd), .instr_rs(instr_rs), .instr_rt(instr_rt),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data),
        .alu_op(alu_op), .alu_rs_val(alu_rs_val), .alu_rt_val(alu_rt_val),
        .alu_result(alu_result),
        .done(done), .done_rd(done_rd), .done_val(done_val)
    );

    function automatic logic [W-1:0] alu_f(input logic [OW-1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        case (op)
            `ALU_OP_ADD: return a + b;
            `ALU_OP_LSL: return a << b[3:0];
            `ALU_OP_AND: return a & b;
            default:     return ~a;
        endcase
    endfunction

    always_comb alu_result = alu_f(alu_op, alu_rs_val, alu_rt_val);

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    logic [W-1:0] m_rf [8];
    logic [W+2:0] sb_q [$];
    int done_cyc [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] mrd(input int i);
        return (R0EN && i == 0) ? '0 : m_rf[i];
    endfunction

    task automatic mwr(input int i, input logic [W-1:0] v);
        if (!(R0EN && i == 0)) m_rf[i] = v;
    endtask

    // Every done pulse is matched against the oldest outstanding expectation.
    task automatic tick();
        logic [W+2:0] e;
        @(posedge clk);
        #1;
        cyc++;
        if (done) begin
            done_cyc.push_back(cyc);
            if (sb_q.size() == 0) chk("done_unexpected", 32'(done), 32'd0);
            else begin
                e = sb_q.pop_front();
                chk("done_rd", 32'(done_rd), 32'(e[W+2:W]));
                chk("done_val", 32'(done_val), 32'(e[W-1:0]));
            end
        end
    endtask

    task automatic load(input logic [2:0] a, input logic [W-1:0] d);
        ld_valid = 1'b1; ld_addr = a; ld_data = d;
        tick();
        ld_valid = 1'b0;
        mwr(int'(a), d);
    endtask

    task automatic dbg_chk(input logic [2:0] a, input string tag);
        dbg_addr = a;
        tick();
        chk(tag, 32'(dbg_data), 32'(mrd(int'(a))));
    endtask

    task automatic issue(input logic [OW-1:0] op, input logic [2:0] rd, input logic [2:0] rs,
                         input logic [2:0] rt, input bit poke_ld, output int waits);
        logic [W-1:0] a, b, r;
        a = mrd(int'(rs)); b = mrd(int'(rt)); r = alu_f(op, a, b);
        instr_valid = 1'b1; instr_op = op; instr_rd = rd; instr_rs = rs; instr_rt = rt;
        #1;
        waits = 0;
        while (!instr_ready && waits < 10) begin tick(); waits++; end
        chk("accept_timeout", 32'(waits < 10), 32'd1);
        sb_q.push_back({rd, r});
        tick();
        instr_valid = 1'b0;
        chk("alu_rs_val", 32'(alu_rs_val), 32'(a));
        chk("alu_rt_val", 32'(alu_rt_val), 32'(b));
        chk("alu_op", 32'(alu_op), 32'(op));
        chk("ready_in_issue", 32'(instr_ready), 32'd0);
        if (poke_ld) begin ld_valid = 1'b1; ld_addr = 3'd7; ld_data = W'(16'hBEEF); end
        tick();
        ld_valid = 1'b0;
        chk("done_pulse", 32'(done), 32'd1);
        mwr(int'(rd), r);
        tick();
        chk("done_low", 32'(done), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int n;
        int acc [3];
        logic [OW-1:0] b_op [3];
        logic [2:0]    b_rd [3], b_rs [3], b_rt [3];
        logic [W-1:0]  ea, eb;

        for (int i = 0; i < 8; i++) m_rf[i] = '0;
        #23 reset_n = 1'b1;
        chk("rst_ready", 32'(instr_ready), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_alu_op", 32'(alu_op), 32'd0);
        chk("rst_rs_val", 32'(alu_rs_val), 32'd0);
        chk("rst_done_val", 32'(done_val), 32'd0);
        for (int i = 0; i < 8; i++) dbg_chk(3'(i), "dbg_reset");

        load(3'd1, W'(16'h0003));
        load(3'd2, W'(16'h0005));
        issue(`ALU_OP_ADD, 3'd3, 3'd1, 3'd2, 1'b0, w);
        dbg_chk(3'd3, "dbg_r3_add");

        issue(`ALU_OP_LSL, 3'd4, 3'd1, 3'd1, 1'b0, w);
        issue(`ALU_OP_NOT, 3'd4, 3'd4, 3'd0, 1'b0, w);
        dbg_chk(3'd4, "dbg_r4_not");

        // Load and instruction together: load wins, instruction accepted one cycle later.
        ld_valid = 1'b1; ld_addr = 3'd5; ld_data = W'(16'h00AA);
        instr_valid = 1'b1; instr_op = `ALU_OP_AND; instr_rd = 3'd6; instr_rs = 3'd5; instr_rt = 3'd5;
        #1;
        chk("ready_low_on_load", 32'(instr_ready), 32'd0);
        tick();
        ld_valid = 1'b0;
        mwr(5, W'(16'h00AA));
        issue(`ALU_OP_AND, 3'd6, 3'd5, 3'd5, 1'b1, w);
        chk("accept_after_load", 32'(w), 32'd0);
        dbg_chk(3'd7, "ld_in_issue_dropped");
        dbg_chk(3'd6, "dbg_r6_and");

        // Back-to-back with instr_valid held high.
        b_op = '{`ALU_OP_ADD, `ALU_OP_ADD, `ALU_OP_AND};
        b_rd = '{3'd1, 3'd1, 3'd3};
        b_rs = '{3'd1, 3'd1, 3'd1};
        b_rt = '{3'd2, 3'd2, 3'd2};
        done_cyc.delete();
        instr_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            instr_op = b_op[k]; instr_rd = b_rd[k]; instr_rs = b_rs[k]; instr_rt = b_rt[k];
            #1;
            n = 0;
            while (!instr_ready && n < 10) begin tick(); n++; end
            acc[k] = cyc;
            ea = mrd(int'(b_rs[k])); eb = mrd(int'(b_rt[k]));
            sb_q.push_back({b_rd[k], alu_f(b_op[k], ea, eb)});
            mwr(int'(b_rd[k]), alu_f(b_op[k], ea, eb));
            tick();
        end
        instr_valid = 1'b0;
        repeat (4) tick();
        chk("b2b_accept_gap0", 32'(acc[1] - acc[0]), 32'd3);
        chk("b2b_accept_gap1", 32'(acc[2] - acc[1]), 32'd3);
        chk("b2b_done_count", 32'(done_cyc.size()), 32'd3);
        if (done_cyc.size() == 3) begin
            chk("b2b_done_gap0", 32'(done_cyc[1] - done_cyc[0]), 32'd3);
            chk("b2b_done_gap1", 32'(done_cyc[2] - done_cyc[1]), 32'd3);
        end
        dbg_chk(3'd1, "dbg_r1_b2b");
        dbg_chk(3'd3, "dbg_r3_b2b");

        // Register 0 behaviour under either build.
        load(3'd0, W'(16'h1234));
        dbg_chk(3'd0, "dbg_r0_load");
        issue(`ALU_OP_ADD, 3'd0, 3'd1, 3'd2, 1'b0, w);
        dbg_chk(3'd0, "dbg_r0_wb");
        chk("sb_empty", 32'(sb_q.size()), 32'd0);

        // Reset during ISSUE aborts the instruction.
        instr_valid = 1'b1; instr_op = `ALU_OP_ADD; instr_rd = 3'd2; instr_rs = 3'd1; instr_rt = 3'd2;
        #1;
        n = 0;
        while (!instr_ready && n < 10) begin tick(); n++; end
        tick();
        instr_valid = 1'b0;
        #2 reset_n = 1'b0;
        #2;
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_rs_val", 32'(alu_rs_val), 32'd0);
        #2 reset_n = 1'b1;
        for (int i = 0; i < 8; i++) m_rf[i] = '0;
        repeat (3) begin
            tick();
            chk("abort_no_done", 32'(done), 32'd0);
        end
        for (int i = 0; i < 8; i++) dbg_chk(3'(i), "dbg_after_abort");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
